// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side request/response and data-SRAM bus bundle for dmem_access_ctrl.
// The slave modport is the controller's view; the master modport is the
// surrounding environment (pipeline + SRAM), which drives the opposite directions.
interface dmem_access_ctrl_if;
  // Pipeline MEM-stage request
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Data SRAM bus
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // Response / status back to the pipeline
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stallreq;
  logic        addr_err;
  logic        bus_timeout;

  modport slave (
    input  req_valid, req_wr, req_size, req_sign, req_addr, req_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output resp_valid, resp_rdata, stallreq, addr_err, bus_timeout
  );

  modport master (
    output req_valid, req_wr, req_size, req_sign, req_addr, req_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  resp_valid, resp_rdata, stallreq, addr_err, bus_timeout
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns a MEM-stage load/store into a two-phase
// (address, data) SRAM bus transaction, aligns store data/strobes, extracts and
// extends load data, and stalls the pipeline until the access completes.
module dmem_access_ctrl (
  input  logic             clk,
  input  logic             rst,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_timeout_q, bus_timeout_d;

  logic        req_aligned;
  logic [31:0] load_ext;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Alignment check on the incoming request (size 3 behaves as word)
  always_comb begin
    unique case (bus.req_size)
      2'd0:    req_aligned = 1'b1;
      2'd1:    req_aligned = ~bus.req_addr[0];
      default: req_aligned = (bus.req_addr[1:0] == 2'b00);
    endcase
  end

  // Lane select and sign/zero extension of the returned read word
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    load_byte = bus.data_rdata[7:0];
      2'd1:    load_byte = bus.data_rdata[15:8];
      2'd2:    load_byte = bus.data_rdata[23:16];
      default: load_byte = bus.data_rdata[31:24];
    endcase
    load_half = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    unique case (size_q)
      2'd0:    load_ext = {{24{sign_q & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{sign_q & load_half[15]}}, load_half};
      default: load_ext = bus.data_rdata;
    endcase
  end

  // Next-state: FSM, watchdog, request latch, response capture, status pulses
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    wr_d          = wr_q;
    size_d        = size_q;
    sign_d        = sign_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    addr_err_d    = 1'b0;
    bus_timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_aligned) begin
            wr_d    = bus.req_wr;
            size_d  = bus.req_size;
            sign_d  = bus.req_sign;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = StAddr;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            rdata_d = wr_q ? 32'h0 : load_ext;
            state_d = StDone;
          end else begin
            wd_d    = 8'h00;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (bus.data_data_ok) begin
          rdata_d = wr_q ? 32'h0 : load_ext;
          state_d = StDone;
        end else if (wd_q == 8'hFF) begin
          bus_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wd_q          <= 8'h00;
      wr_q          <= 1'b0;
      size_q        <= 2'd0;
      sign_q        <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      rdata_q       <= 32'h0;
      addr_err_q    <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      wr_q          <= wr_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      addr_err_q    <= addr_err_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  // Bus and pipeline outputs; bus fields are forced to zero outside the address phase
  always_comb begin
    bus.data_req   = (state_q == StAddr);
    bus.data_wr    = bus.data_req & wr_q;
    bus.data_addr  = bus.data_req ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = 32'h0;
    if (bus.data_wr) begin
      unique case (size_q)
        2'd0: begin
          bus.data_wstrb = 4'b0001 << addr_q[1:0];
          bus.data_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          bus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          bus.data_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          bus.data_wstrb = 4'b1111;
          bus.data_wdata = wdata_q;
        end
      endcase
    end
    bus.stallreq    = ((state_q == StIdle) & bus.req_valid & req_aligned) |
                      (state_q == StAddr) | (state_q == StData);
    bus.resp_valid  = (state_q == StDone);
    bus.resp_rdata  = bus.resp_valid ? rdata_q : 32'h0;
    bus.addr_err    = addr_err_q;
    bus.bus_timeout = bus_timeout_q;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high; clock clk.
REQ-003 req_valid  input  1  MEM-stage memory op present, held stable while stallreq=1.
REQ-004 req_wr  input  1  1=store, 0=load.
REQ-005 req_size  input  2  0=byte, 1=half, 2=word; 3 treated as word.
REQ-006 req_sign  input  1  load sign-extend (1) / zero-extend (0).
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 data_req  output  1  bus request to data SRAM.
REQ-010 data_wr  output  1  bus write flag.
REQ-011 data_wstrb  output  4  byte-lane write strobes.
REQ-012 data_addr  output  32  bus address, word-aligned ({addr[31:2],2'b00}).
REQ-013 data_wdata  output  32  lane-replicated store data.
REQ-014 data_addr_ok  input  1  bus accepted address this cycle.
REQ-015 data_data_ok  input  1  bus completed data phase this cycle.
REQ-016 data_rdata  input  32  read word, valid with data_data_ok.
REQ-017 resp_valid  output  1  one-cycle pulse: access complete.
REQ-018 resp_rdata  output  32  extracted/extended load result, valid with resp_valid.
REQ-019 stallreq  output  1  request to pipeline control to hold IF..MEM.
REQ-020 addr_err  output  1  one-cycle pulse: misaligned request rejected.
REQ-021 bus_timeout  output  1  one-cycle pulse: data phase watchdog expired.

Function
REQ-022 FSM states IDLE, ADDR, DATA, DONE; encoding free.
REQ-023 IDLE: req_valid & aligned -> latch wr/size/sign/addr/wdata, go ADDR; req_valid & misaligned -> addr_err=1 next cycle, stay IDLE, no bus activity.
REQ-024 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; bytes never misaligned.
REQ-025 stallreq = (IDLE & req_valid & aligned) | ADDR | DATA; 0 in DONE and on misaligned.
REQ-026 ADDR: data_req=1 with latched fields; addr_ok & data_ok same cycle -> DONE; addr_ok only -> DATA; else hold.
REQ-027 DATA: data_req=0; data_ok -> DONE; watchdog counter (8-bit, cleared on entry) increments each cycle; at count 255 without data_ok -> bus_timeout pulse, IDLE, stallreq drops.
REQ-028 DONE: resp_valid=1 for exactly one cycle, resp_rdata driven from the data captured at data_ok; unconditionally -> IDLE; req_valid ignored in DONE.
REQ-029 Minimum latency: request accepted cycle N, addr_ok&data_ok in cycle N+1, resp_valid in cycle N+2.
REQ-030 Store strobes: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-031 Store data: byte replicated x4, half replicated x2, word as-is.
REQ-032 Load extraction: select byte/half by addr[1:0]; extend by req_sign to 32 bits; word unchanged.
REQ-033 Stores also produce resp_valid; resp_rdata=0 for stores.
REQ-034 data_ok/addr_ok in IDLE or DONE ignored (stale/abandoned transactions).
REQ-035 data_wr/data_wstrb/data_addr/data_wdata = 0 whenever data_req=0.

Reset
REQ-036 rst=1: state IDLE, watchdog 0, latched fields 0; all outputs 0 the following cycle.
REQ-037 rst mid-ADDR/DATA abandons transaction; a later data_ok is ignored per REQ-034.

Verification
REQ-038 lbu addr 0x1003, rdata 0x80AA55CC, immediate ok -> data_addr 0x1000, resp_rdata 0x00000080, stallreq high 2 cycles.
REQ-039 lh addr 0x2002, rdata 0x8001FFFF, addr_ok cycle 1, data_ok cycle 3 -> resp_rdata 0xFFFF8001, state path ADDR,DATA,DATA,DONE.
REQ-040 sb addr 0x11, wdata 0x000000AB -> data_wstrb 4'b0010, data_wdata 0xABABABAB, data_wr=1.
REQ-041 lw addr 0x6 -> addr_err pulse, data_req never asserted, stallreq 0.
REQ-042 lw with addr_ok, no data_ok for 255 cycles -> bus_timeout pulse, IDLE; then rst asserted during a new ADDR -> all outputs 0 next cycle, late data_ok ignored.
